bp_controller: RTL and testbench

- Direction-prediction controller that drives the two read ports and the write port of the tagged 2-bit-counter branch-prediction cache.
- Fetch side: combinational taken/not-taken guess for the fetched PC.
- Execute side: reads the counter for the resolved branch, computes the saturating update, and issues the write one cycle later through a registered update stage.
- Bypass logic hides the read-after-write window between the update stage and the cache array.

---
 rtl/bp_pkg.sv | 22 ++
 rtl/bp_controller_if.sv | 38 +++
 rtl/bp_sat_counter.sv | 52 +++++
 rtl/bp_controller.sv | 131 +++++++++++++
 tb/tb_bp_controller.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : bp_pkg                                                     |
// | Description : Shared constants for the branch-direction predictor:       |
// |               default counter width, allocate values for a fresh line    |
// |               and the PC-to-cache-index shift.                           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package bp_pkg;

  // Default saturating-counter width; the MSB is the taken/not-taken guess.
  localparam int DEF_CNT_WIDTH = 2;

  // Values written when a branch allocates a new line (2-bit counters).
  localparam logic [1:0] CNT_WEAK_T  = 2'b10;  // weakly taken
  localparam logic [1:0] CNT_WEAK_NT = 2'b01;  // weakly not-taken

  // Instructions are word aligned, so the two LSBs of the PC carry no index.
  localparam int PC_SHIFT = 2;

endpackage
`default_nettype wire

// File: rtl/bp_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : bp_controller_if                                           |
// | Description : Bus between the prediction controller and the tagged       |
// |               2-bit-counter cache: two read ports and one write port.    |
// |   bc_ra0/bc_dout0/bc_hit0 : read port 0 (fetch)                          |
// |   bc_ra1/bc_dout1/bc_hit1 : read port 1 (execute)                        |
// |   bc_wa/bc_din/bc_we      : write port                                   |
// |   modport master : controller side      modport slave : cache side       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface bp_controller_if
  import bp_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
  logic [PC_WIDTH-PC_SHIFT-1:0] bc_ra0;
  logic [CNT_WIDTH-1:0]         bc_dout0;
  logic                         bc_hit0;
  logic [PC_WIDTH-PC_SHIFT-1:0] bc_ra1;
  logic [CNT_WIDTH-1:0]         bc_dout1;
  logic                         bc_hit1;
  logic [PC_WIDTH-PC_SHIFT-1:0] bc_wa;
  logic [CNT_WIDTH-1:0]         bc_din;
  logic                         bc_we;

  modport master (
    output bc_ra0, bc_ra1, bc_wa, bc_din, bc_we,
    input  bc_dout0, bc_hit0, bc_dout1, bc_hit1
  );

  modport slave (
    input  bc_ra0, bc_ra1, bc_wa, bc_din, bc_we,
    output bc_dout0, bc_hit0, bc_dout1, bc_hit1
  );
endinterface
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bp_sat_counter                                             |
// | Description : Combinational next-value of a saturating direction         |
// |               counter. On a hit it steps towards the outcome and clamps  |
// |               at all-ones / zero; on a miss it allocates a weak value.   |
// |   cur   : current counter        hit   : counter is valid               |
// |   taken : resolved outcome       nxt   : updated counter                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  wire logic [CNT_WIDTH-1:0] cur,
  input  wire logic                 hit,
  input  wire logic                 taken,
  output logic      [CNT_WIDTH-1:0] nxt
);

  localparam logic [CNT_WIDTH-1:0] C_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] C_MIN = '0;

  logic [CNT_WIDTH-1:0] w_weak_t;
  logic [CNT_WIDTH-1:0] w_weak_nt;

  // Weak values are "1 then zeros" and "0 then ones"; for the common
  // 2-bit case they come straight from the shared package.
  generate
    if (CNT_WIDTH == 2) begin : g_weak_pkg
      assign w_weak_t  = CNT_WEAK_T;
      assign w_weak_nt = CNT_WEAK_NT;
    end else begin : g_weak_gen
      assign w_weak_t  = {1'b1, {(CNT_WIDTH-1){1'b0}}};
      assign w_weak_nt = {1'b0, {(CNT_WIDTH-1){1'b1}}};
    end
  endgenerate

  always_comb begin
    nxt = cur;
    if (!hit) begin
      nxt = taken ? w_weak_t : w_weak_nt;
    end else if (taken) begin
      if (cur != C_MAX) nxt = cur + CNT_WIDTH'(1);
    end else begin
      if (cur != C_MIN) nxt = cur - CNT_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bp_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bp_controller                                              |
// | Description : Branch-direction prediction controller. Drives the two     |
// |               read ports and the write port of the counter cache:        |
// |               combinational fetch guess, execute-side saturating update  |
// |               issued one cycle later from a registered update stage,     |
// |               and bypass of that stage onto both read ports.             |
// | Ports       : clk, reset (async, active high), stall                     |
// |               pc_guess/is_br_guess -> br_taken   (fetch)                 |
// |               pc_check/is_br_check/br_taken_check/br_pred_check (exec)   |
// |               bc (bp_controller_if.master) cache bus                     |
// |               stat_branches/stat_mispred statistics                      |
// | Options     : BP_STATS_EN - enables the statistics counters; otherwise   |
// |               both statistics outputs are tied to zero.                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module bp_controller
  import bp_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int STAT_WIDTH = 32
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  stall,
  input  wire logic [PC_WIDTH-1:0]   pc_guess,
  input  wire logic                  is_br_guess,
  output logic                       br_taken,
  input  wire logic [PC_WIDTH-1:0]   pc_check,
  input  wire logic                  is_br_check,
  input  wire logic                  br_taken_check,
  input  wire logic                  br_pred_check,
  bp_controller_if.master            bc,
  output logic [STAT_WIDTH-1:0]      stat_branches,
  output logic [STAT_WIDTH-1:0]      stat_mispred
);

  localparam int AW = PC_WIDTH - PC_SHIFT;

  logic [AW-1:0]        w_ra0;
  logic [AW-1:0]        w_ra1;
  logic                 w_byp0;
  logic                 w_byp1;
  logic [CNT_WIDTH-1:0] w_cnt0;
  logic [CNT_WIDTH-1:0] w_cnt1;
  logic                 w_hit0;
  logic                 w_hit1;
  logic [CNT_WIDTH-1:0] w_next;
  logic                 w_capture;
  logic                 w_unused_pc_lo;

  logic                 r_upd_valid;
  logic [AW-1:0]        r_upd_addr;
  logic [CNT_WIDTH-1:0] r_upd_data;

  assign w_ra0 = pc_guess[PC_WIDTH-1:PC_SHIFT];
  assign w_ra1 = pc_check[PC_WIDTH-1:PC_SHIFT];
  assign w_unused_pc_lo = ^{pc_guess[PC_SHIFT-1:0], pc_check[PC_SHIFT-1:0]};

  assign bc.bc_ra0 = w_ra0;
  assign bc.bc_ra1 = w_ra1;
  assign bc.bc_we  = r_upd_valid;
  assign bc.bc_wa  = r_upd_addr;
  assign bc.bc_din = r_upd_data;

  // The array only reflects a write one cycle after bc_we; during that
  // cycle the pending value is forwarded so neither port sees stale data.
  assign w_byp0 = r_upd_valid && (r_upd_addr == w_ra0);
  assign w_byp1 = r_upd_valid && (r_upd_addr == w_ra1);
  assign w_cnt0 = w_byp0 ? r_upd_data : bc.bc_dout0;
  assign w_cnt1 = w_byp1 ? r_upd_data : bc.bc_dout1;
  assign w_hit0 = w_byp0 | bc.bc_hit0;
  assign w_hit1 = w_byp1 | bc.bc_hit1;

  // A miss predicts not-taken.
  assign br_taken = is_br_guess & w_hit0 & w_cnt0[CNT_WIDTH-1];

  assign w_capture = is_br_check & ~stall;

  bp_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_sat_counter (
    .cur   (w_cnt1),
    .hit   (w_hit1),
    .taken (br_taken_check),
    .nxt   (w_next)
  );

  // Stall only gates capture; a write already in the stage always drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_upd_valid <= 1'b0;
      r_upd_addr  <= '0;
      r_upd_data  <= '0;
    end else begin
      r_upd_valid <= w_capture;
      if (w_capture) begin
        r_upd_addr <= w_ra1;
        r_upd_data <= w_next;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [STAT_WIDTH-1:0] r_stat_branches;
  logic [STAT_WIDTH-1:0] r_stat_mispred;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_branches <= '0;
      r_stat_mispred  <= '0;
    end else if (w_capture) begin
      r_stat_branches <= r_stat_branches + STAT_WIDTH'(1);
      if (br_pred_check != br_taken_check)
        r_stat_mispred <= r_stat_mispred + STAT_WIDTH'(1);
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_mispred  = r_stat_mispred;
`else
  logic w_unused_stats;
  assign w_unused_stats = br_pred_check ^ br_taken_check;
  assign stat_branches  = '0;
  assign stat_mispred   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_bp_controller                                           |
// | Description : Self-checking bench for bp_controller. Provides a tagged   |
// |               counter-cache model on the bus and compares every cycle    |
// |               against a per-branch counter map kept by the bench.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_bp_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] pc_guess;
  logic        is_br_guess;
  logic        br_taken;
  logic [31:0] pc_check;
  logic        is_br_check;
  logic        br_taken_check;
  logic        br_pred_check;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bp_controller_if #(.PC_WIDTH(32), .CNT_WIDTH(2)) bc_if ();

  bp_controller #(
    .PC_WIDTH   (32),
    .CNT_WIDTH  (2),
    .STAT_WIDTH (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .pc_guess       (pc_guess),
    .is_br_guess    (is_br_guess),
    .br_taken       (br_taken),
    .pc_check       (pc_check),
    .is_br_check    (is_br_check),
    .br_taken_check (br_taken_check),
    .br_pred_check  (br_pred_check),
    .bc             (bc_if),
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
  );

  // Tagged counter array on the cache side, indexed by address[11:0].
  // All PCs used below differ in those bits, so lines never alias.
  logic        c_valid [4096];
  logic [29:0] c_tag   [4096];
  logic [1:0]  c_cnt   [4096];

  assign bc_if.bc_dout0 = c_cnt[bc_if.bc_ra0[11:0]];
  assign bc_if.bc_hit0  = c_valid[bc_if.bc_ra0[11:0]] && (c_tag[bc_if.bc_ra0[11:0]] == bc_if.bc_ra0);
  assign bc_if.bc_dout1 = c_cnt[bc_if.bc_ra1[11:0]];
  assign bc_if.bc_hit1  = c_valid[bc_if.bc_ra1[11:0]] && (c_tag[bc_if.bc_ra1[11:0]] == bc_if.bc_ra1);

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) c_valid[i] <= 1'b0;
    end else if (bc_if.bc_we) begin
      c_valid[bc_if.bc_wa[11:0]] <= 1'b1;
      c_tag[bc_if.bc_wa[11:0]]   <= bc_if.bc_wa;
      c_cnt[bc_if.bc_wa[11:0]]   <= bc_if.bc_din;
    end
  end

  // Reference: counter value per branch address as seen once every
  // accepted resolution has taken effect.
  int          m_cnt [int];
  logic        exp_we;
  logic [29:0] exp_wa;
  logic [1:0]  exp_din;
  logic [31:0] m_br;
  logic [31:0] m_mp;

  function automatic int model_next(bit hit, int cur, bit taken);
    if (!hit) return taken ? 2 : 1;
    if (taken) return (cur < 3) ? cur + 1 : 3;
    return (cur > 0) ? cur - 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check fetch-side outputs before the edge, advance the model
  // on the edge, then check the update stage and statistics after it.
  task automatic tick(input string tag);
    int a0, a1, c0, c1, nxt;
    bit h0, h1, cap;
    logic [31:0] e_sb, e_sm;
    #1;
    a0 = int'(pc_guess[31:2]);
    a1 = int'(pc_check[31:2]);
    h0 = m_cnt.exists(a0);
    h1 = m_cnt.exists(a1);
    c0 = h0 ? m_cnt[a0] : 0;
    c1 = h1 ? m_cnt[a1] : 0;
    check({tag, " br_taken"}, br_taken, (is_br_guess && h0 && c0 >= 2));
    check({tag, " ra0"}, bc_if.bc_ra0, pc_guess[31:2]);
    check({tag, " ra1"}, bc_if.bc_ra1, pc_check[31:2]);
    cap = is_br_check && !stall;
    nxt = model_next(h1, c1, br_taken_check);
    @(posedge clk);
    if (reset) begin
      m_cnt.delete();
      exp_we = 1'b0; exp_wa = '0; exp_din = '0; m_br = '0; m_mp = '0;
    end else begin
      exp_we = cap;
      if (cap) begin
        exp_wa    = 30'(a1);
        exp_din   = 2'(nxt);
        m_cnt[a1] = nxt;
        m_br++;
        if (br_pred_check != br_taken_check) m_mp++;
      end
    end
    #1;
    check({tag, " we"}, bc_if.bc_we, exp_we);
    if (exp_we || reset) begin
      check({tag, " wa"}, bc_if.bc_wa, exp_wa);
      check({tag, " din"}, bc_if.bc_din, exp_din);
    end
`ifdef BP_STATS_EN
    e_sb = m_br; e_sm = m_mp;
`else
    e_sb = '0; e_sm = '0;
`endif
    check({tag, " stat_br"}, stat_branches, e_sb);
    check({tag, " stat_mp"}, stat_mispred, e_sm);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic pred);
    is_br_check = 1'b1; pc_check = pc; br_taken_check = taken; br_pred_check = pred;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; pc_guess = '0; is_br_guess = 1'b0;
    pc_check = '0; is_br_check = 1'b0; br_taken_check = 1'b0; br_pred_check = 1'b0;
    tick("reset");
    reset = 1'b0;

    // Cold miss, then visible via bypass and then via the array.
    pc_guess = 32'h1000; is_br_guess = 1'b1;
    resolve(32'h1000, 1'b1, 1'b0);
    tick("cold_res");
    check("cold_wa_const", bc_if.bc_wa, 30'h400);
    check("cold_din_const", bc_if.bc_din, 2'b10);
    is_br_check = 1'b0;
    tick("cold_byp");
    tick("cold_arr");
    check("cold_taken_const", br_taken, 1'b1);

    // Saturation at both ends, back to back.
    is_br_guess = 1'b0;
    for (int i = 0; i < 5; i++) begin
      resolve(32'h3000, 1'b1, 1'b1);
      tick("sat_hi");
    end
    check("sat_hi_const", bc_if.bc_din, 2'b11);
    for (int i = 0; i < 3; i++) begin
      resolve(32'h3004, 1'b0, 1'b0);
      tick("sat_lo");
    end
    check("sat_lo_const", bc_if.bc_din, 2'b00);

    // Bypass: line at 01, taken twice in consecutive cycles.
    resolve(32'h2000, 1'b0, 1'b0);
    tick("byp_init");
    is_br_check = 1'b0;
    tick("byp_idle0");
    tick("byp_idle1");
    resolve(32'h2000, 1'b1, 1'b0);
    tick("byp_n");
    check("byp_n_din", bc_if.bc_din, 2'b10);
    pc_guess = 32'h2000; is_br_guess = 1'b1;
    tick("byp_n1");
    check("byp_n1_din", bc_if.bc_din, 2'b11);
    is_br_check = 1'b0;
    tick("byp_drain");

    // Stall blocks capture; release gives exactly one write.
    resolve(32'h1000, 1'b0, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) tick("stall");
    stall = 1'b0;
    tick("stall_rel");
    is_br_check = 1'b0;
    tick("stall_after");

    // Async reset while an update is pending.
    resolve(32'h1000, 1'b1, 1'b1);
    tick("arst_arm");
    is_br_check = 1'b0; is_br_guess = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_we_now", bc_if.bc_we, 1'b0);
    check("arst_wa_now", bc_if.bc_wa, 30'h0);
    check("arst_din_now", bc_if.bc_din, 2'b00);
    tick("arst_edge");
    reset = 1'b0;
    pc_guess = 32'h1000; is_br_guess = 1'b1;
    tick("arst_after");

    // Statistics: five resolutions, two mispredicted.
    resolve(32'h1000, 1'b1, 1'b1); tick("st0");
    resolve(32'h2000, 1'b1, 1'b0); tick("st1");
    resolve(32'h3000, 1'b0, 1'b0); tick("st2");
    resolve(32'h3004, 1'b0, 1'b1); tick("st3");
    resolve(32'h1000, 1'b1, 1'b1); tick("st4");
    is_br_check = 1'b0;
`ifdef BP_STATS_EN
    check("stats_br_const", stat_branches, 32'd5);
    check("stats_mp_const", stat_mispred, 32'd2);
`else
    check("stats_br_const", stat_branches, 32'd0);
    check("stats_mp_const", stat_mispred, 32'd0);
`endif

    // Randomized traffic over sixteen non-aliasing branches.
    for (int i = 0; i < 400; i++) begin
      pc_guess       = 32'h800 + 32'($urandom_range(0, 15)) * 4;
      is_br_guess    = 1'($urandom_range(0, 1));
      pc_check       = 32'h800 + 32'($urandom_range(0, 15)) * 4;
      is_br_check    = ($urandom_range(0, 3) != 0);
      br_taken_check = 1'($urandom_range(0, 1));
      br_pred_check  = 1'($urandom_range(0, 1));
      stall          = ($urandom_range(0, 3) == 0);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
